mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/mem_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_ctrl_pkg;

    // Level of rst that means "in reset".
    localparam logic RST_ENABLE = 1'b1;

    // mem_width encodings; 2'b11 is treated as a word.
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Number of bytes moved for a given width code.
    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        logic [2:0] n;
        case (width)
            WIDTH_BYTE: n = 3'd1;
            WIDTH_HALF: n = 3'd2;
            default:    n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a single-port byte RAM, one byte per cycle.
// Latency: read of n bytes done n+2 cycles after the request is sampled, write done n+1 cycles after.
// Backpressure: requests are held until the done pulse; mem_stall_request holds the pipeline meanwhile.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stall_request,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    src_e              src_q, src_d;
    // Holds store data on writes, assembles load data on reads.
    logic [31:0]       data_q, data_d;

    logic [1:0]        rd_idx;
    logic [4:0]        rd_sh;
    logic [4:0]        wr_sh;

    // Byte captured this cycle belongs to the address driven one cycle earlier.
    assign rd_idx   = cnt_q[1:0] - 2'd1;
    assign rd_sh    = {rd_idx, 3'b000};
    assign wr_sh    = {cnt_q[1:0], 3'b000};

    // Address wraps naturally at 2^ADDR_W.
    assign ram_addr = base_q + ADDR_W'(cnt_q);
    assign ram_dout = data_q[wr_sh +: 8];

    assign if_done  = (state_q == ST_DONE) && (src_q == SRC_IF);
    assign mem_done = (state_q == ST_DONE) && (src_q == SRC_MEM);
    assign if_data  = if_done  ? data_q : 32'h0;
    assign mem_rdata = mem_done ? data_q : 32'h0;

    assign mem_stall_request = (rst != RST_ENABLE) &&
                               ((if_req && !if_done) || (mem_req && !mem_done));

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            n_q     <= 3'd0;
            base_q  <= '0;
            src_q   <= SRC_IF;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            base_q  <= base_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic, RAM write strobe and byte capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        base_d  = base_q;
        src_d   = src_q;
        data_d  = data_q;
        ram_wr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                // MEM wins over IF so a load/store is never starved by fetches.
                if (mem_req) begin
                    base_d  = mem_addr;
                    n_d     = width_to_bytes(mem_width);
                    src_d   = SRC_MEM;
                    data_d  = mem_we ? mem_wdata : 32'h0;
                    state_d = mem_we ? ST_WRITE : ST_READ;
                end else if (if_req) begin
                    base_d  = if_addr;
                    n_d     = 3'd4;
                    src_d   = SRC_IF;
                    data_d  = 32'h0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q != 3'd0) begin
                    data_d[rd_sh +: 8] = ram_din;
                end
                if (cnt_q == n_q) begin
                    cnt_d   = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                ram_wr = 1'b1;
                if (cnt_q == n_q - 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-RAM model with one-cycle read latency.
// Latency: checks done-pulse cycle numbers relative to the cycle a request is first sampled.
// Backpressure: requests held until their done pulse, then dropped.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall_request;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_wr;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_data           (if_data),
        .if_done           (if_done),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_width         (mem_width),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_done          (mem_done),
        .mem_stall_request (mem_stall_request),
        .ram_addr          (ram_addr),
        .ram_dout          (ram_dout),
        .ram_din           (ram_din),
        .ram_wr            (ram_wr)
    );

    // RAM model: 1 KiB aliased on the low address bits, plus a write log.
    logic [7:0]  ram [0:1023];
    logic        pk_vld = 1'b0;
    logic [9:0]  pk_addr = 10'h0;
    logic [7:0]  pk_dat = 8'h0;
    int          cyc_now = 0;
    int          wr_n = 0;
    logic [31:0] wlog_addr [0:63];
    logic [7:0]  wlog_dat  [0:63];
    int          wlog_cyc  [0:63];

    always @(posedge clk) begin
        cyc_now <= cyc_now + 1;
        ram_din <= ram[ram_addr[9:0]];
        if (pk_vld) begin
            ram[pk_addr] <= pk_dat;
        end
        if (ram_wr) begin
            ram[ram_addr[9:0]]      <= ram_dout;
            wlog_addr[wr_n & 63]    <= ram_addr;
            wlog_dat[wr_n & 63]     <= ram_dout;
            wlog_cyc[wr_n & 63]     <= cyc_now;
            wr_n                    <= wr_n + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pk_vld  = 1'b1;
        pk_addr = a;
        pk_dat  = d;
        tick();
        pk_vld  = 1'b0;
    endtask

    // ram_addr seen in each cycle of the last transaction, indexed by relative cycle.
    logic [31:0] ra [0:15];

    // Waits for the done pulse; returns its cycle relative to t0 (-1 on timeout).
    task automatic wait_done(input bit is_mem, input int t0, input int budget,
                             output int cyc, output logic [31:0] data,
                             output int stall_hi, output logic stall_at_done);
        cyc = -1;
        data = 32'h0;
        stall_hi = 0;
        stall_at_done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            ra[(cyc_now - t0) & 15] = ram_addr;
            if (is_mem ? mem_done : if_done) begin
                cyc = cyc_now - t0;
                data = is_mem ? mem_rdata : if_data;
                stall_at_done = mem_stall_request;
                break;
            end
            if (mem_stall_request) stall_hi++;
            tick();
        end
        if (cyc >= 0) tick();
    endtask

    task automatic start_mem(input logic we, input logic [1:0] w, input logic [31:0] a,
                             input logic [31:0] wd, output int t0);
        mem_we    = we;
        mem_width = w;
        mem_addr  = a;
        mem_wdata = wd;
        mem_req   = 1'b1;
        t0        = cyc_now;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          t0, cyc, sh, w0, dones;
        logic [31:0] d;
        logic        sd;

        rst = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h100;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_width = 2'b10;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;

        // Reset holds everything quiet even with both requests high.
        repeat (2) tick();
        @(negedge clk);
        check("rst_if_done",   {31'h0, if_done}, 32'h0);
        check("rst_mem_done",  {31'h0, mem_done}, 32'h0);
        check("rst_if_data",   if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_stall",     {31'h0, mem_stall_request}, 32'h0);
        check("rst_ram_wr",    {31'h0, ram_wr}, 32'h0);
        tick();
        if_req = 1'b0;
        mem_req = 1'b0;

        poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h10); poke(10'h103, 8'h00);
        poke(10'h200, 8'h11); poke(10'h201, 8'h22); poke(10'h202, 8'h33); poke(10'h203, 8'h44);
        poke(10'h300, 8'h55); poke(10'h301, 8'h55); poke(10'h302, 8'h55); poke(10'h303, 8'h55);
        poke(10'h3FE, 8'hA1); poke(10'h3FF, 8'h80); poke(10'h000, 8'hC3); poke(10'h001, 8'hD4);
        rst = 1'b0;

        // Word fetch from 0x100.
        if_addr = 32'h100;
        if_req  = 1'b1;
        t0      = cyc_now;
        wait_done(1'b0, t0, 20, cyc, d, sh, sd);
        if_req  = 1'b0;
        check("fetch_cycle", cyc, 6);
        check("fetch_data", d, 32'h00100513);
        check("fetch_stall_cycles", sh, 6);
        check("fetch_stall_at_done", {31'h0, sd}, 32'h0);
        check("fetch_addr_c4", ra[4], 32'h103);

        // Simultaneous IF and MEM word load: MEM first, IF afterwards.
        if_req = 1'b1;
        start_mem(1'b0, 2'b10, 32'h200, 32'h0, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("both_mem_cycle", cyc, 6);
        check("both_mem_data", d, 32'h44332211);
        wait_done(1'b0, t0, 20, cyc, d, sh, sd);
        if_req = 1'b0;
        check("both_if_cycle", cyc, 13);
        check("both_if_data", d, 32'h00100513);

        // Half load.
        start_mem(1'b0, 2'b01, 32'h100, 32'h0, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("half_ld_cycle", cyc, 4);
        check("half_ld_data", d, 32'h00000513);

        // Half store 0xDEADBEEF to 0x301.
        w0 = wr_n;
        start_mem(1'b1, 2'b01, 32'h301, 32'hDEADBEEF, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("half_st_cycle", cyc, 3);
        check("half_st_nwr", wr_n - w0, 2);
        check("half_st_a0", wlog_addr[w0 & 63], 32'h301);
        check("half_st_d0", {24'h0, wlog_dat[w0 & 63]}, 32'hEF);
        check("half_st_c0", wlog_cyc[w0 & 63] - t0, 1);
        check("half_st_a1", wlog_addr[(w0 + 1) & 63], 32'h302);
        check("half_st_d1", {24'h0, wlog_dat[(w0 + 1) & 63]}, 32'hBE);
        check("half_st_c1", wlog_cyc[(w0 + 1) & 63] - t0, 2);
        check("half_st_303", {24'h0, ram[10'h303]}, 32'h55);
        check("half_st_300", {24'h0, ram[10'h300]}, 32'h55);

        // Byte load at the top of the address space.
        start_mem(1'b0, 2'b00, 32'hFFFFFFFF, 32'h0, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("byte_ld_cycle", cyc, 3);
        check("byte_ld_data", d, 32'h00000080);

        // Word load straddling the wrap.
        start_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("wrap_ld_cycle", cyc, 6);
        check("wrap_ld_data", d, 32'hD4C380A1);
        check("wrap_addr_c1", ra[1], 32'hFFFFFFFE);
        check("wrap_addr_c2", ra[2], 32'hFFFFFFFF);
        check("wrap_addr_c3", ra[3], 32'h00000000);
        check("wrap_addr_c4", ra[4], 32'h00000001);

        // Reset in cycle 2 of a word store.
        w0 = wr_n;
        start_mem(1'b1, 2'b10, 32'h200, 32'hCAFEF00D, t0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_ram_wr", {31'h0, ram_wr}, 32'h0);
        check("abort_stall", {31'h0, mem_stall_request}, 32'h0);
        mem_req = 1'b0;
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_done || if_done) dones++;
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_done || if_done) dones++;
            tick();
        end
        check("abort_no_done", dones, 0);
        check("abort_nwr", wr_n - w0, 1);
        check("abort_a0", wlog_addr[w0 & 63], 32'h200);
        check("abort_d0", {24'h0, wlog_dat[w0 & 63]}, 32'h0D);
        check("abort_201", {24'h0, ram[10'h201]}, 32'h22);

        // Normal traffic after reset release.
        start_mem(1'b1, 2'b10, 32'h200, 32'h01020304, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("word_st_cycle", cyc, 5);
        start_mem(1'b1, 2'b00, 32'h203, 32'hAAAAAA77, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("byte_st_cycle", cyc, 2);
        start_mem(1'b0, 2'b10, 32'h200, 32'h0, t0);
        wait_done(1'b1, t0, 20, cyc, d, sh, sd);
        mem_req = 1'b0;
        check("readback_cycle", cyc, 6);
        check("readback_data", d, 32'h77020304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
